// File: rtl/pb_conditioner.sv
// pb_conditioner: synchronizes and debounces raw pushbuttons into a clean level plus press/release pulses.
// Define PB_LONG_PRESS_EN to add a per-channel long-press pulse on pb_long.
module pb_conditioner #(
  parameter int NUM_PB          = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 1000000
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NUM_PB-1:0] pb_raw,
  output logic [NUM_PB-1:0] pb_level,
  output logic [NUM_PB-1:0] pb_press,
  output logic [NUM_PB-1:0] pb_release,
  output logic [NUM_PB-1:0] pb_long
);
  typedef enum logic [1:0] {LOW, RISE_WAIT, HIGH, FALL_WAIT} state_t;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [NUM_PB-1:0] sync1, sync2;
  if (NUM_PB < 1 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_params
    $error("pb_conditioner: NUM_PB, DEBOUNCE_CYCLES and LONG_CYCLES must all be >= 1");
  end
  always_ff @(posedge clk)
    if (!nrst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pb_raw;
      sync2 <= sync1;
    end
  for (genvar g = 0; g < NUM_PB; g++) begin : g_ch
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic s, level, level_n, press, press_n, rel, rel_n;
    assign s = sync2[g];
    always_ff @(posedge clk)
      if (!nrst) begin
        state <= LOW;
        cnt   <= '0;
        level <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
        level <= level_n;
        press <= press_n;
        rel   <= rel_n;
      end
    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      level_n = level;
      press_n = 1'b0;
      rel_n   = 1'b0;
      case (state)
        LOW:
          if (s) begin
            state_n = RISE_WAIT;
            cnt_n   = CW'(1);
          end
        RISE_WAIT:
          if (!s) begin
            state_n = LOW;
            cnt_n   = '0;
          end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
            state_n = HIGH;
            cnt_n   = '0;
            level_n = 1'b1;
            press_n = 1'b1;
          end else cnt_n = cnt + 1'b1;
        HIGH:
          if (!s) begin
            state_n = FALL_WAIT;
            cnt_n   = CW'(1);
          end
        FALL_WAIT:
          if (s) begin
            state_n = HIGH;
            cnt_n   = '0;
          end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
            state_n = LOW;
            cnt_n   = '0;
            level_n = 1'b0;
            rel_n   = 1'b1;
          end else cnt_n = cnt + 1'b1;
        default: state_n = LOW;
      endcase
    end
    assign pb_level[g]   = level;
    assign pb_press[g]   = press;
    assign pb_release[g] = rel;
`ifdef PB_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    logic [LW-1:0] hcnt;
    logic          long_q;
    // Hold time keeps accumulating across a bounced release; only a fresh press restarts it.
    always_ff @(posedge clk)
      if (!nrst) begin
        hcnt   <= '0;
        long_q <= 1'b0;
      end else begin
        long_q <= (state == HIGH) && (hcnt == LW'(LONG_CYCLES - 1));
        if (state == RISE_WAIT && state_n == HIGH) hcnt <= '0;
        else if (state == HIGH && hcnt != LW'(LONG_CYCLES)) hcnt <= hcnt + 1'b1;
      end
    assign pb_long[g] = long_q;
`else
    assign pb_long[g] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_pb_conditioner.sv
// tb_pb_conditioner: scoreboard bench for pb_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_pb_conditioner;
  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [1:0] pb_raw = 2'b00;
  logic [1:0] pb_level, pb_press, pb_release, pb_long;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int vectors = 0;
  int miscompares = 0;
`ifdef PB_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  pb_conditioner #(.NUM_PB(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)) dut (
    .clk(clk), .nrst(nrst), .pb_raw(pb_raw), .pb_level(pb_level),
    .pb_press(pb_press), .pb_release(pb_release), .pb_long(pb_long)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pk(input logic [1:0] l, input logic [1:0] p, input logic [1:0] r, input logic [1:0] g);
    return {l, p, r, g};
  endfunction

  // Expected outputs after the edge that samples these inputs go in with the stimulus.
  task automatic drive(input logic [1:0] raw, input logic rst_n, input logic [7:0] e);
    pb_raw = raw;
    nrst = rst_n;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    obs_q.push_back({pb_level, pb_press, pb_release, pb_long});
  endtask

  task automatic test_reset;
    logic [7:0] e, o;
    int n = 0;
    for (int i = 0; i < 3; i++) drive(2'b11, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) drive(2'b11, 1'b1, pk(i >= 6 ? 2'b11 : 2'b00, i == 6 ? 2'b11 : 2'b00, 2'b00, 2'b00));
    for (int i = 0; i < 10; i++) drive(2'b00, 1'b1, pk(i < 6 ? 2'b11 : 2'b00, 2'b00, i == 6 ? 2'b11 : 2'b00, 2'b00));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset vec %0d: lvl/prs/rel/lng got %b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_clean_press;
    logic [7:0] e, o;
    int n = 0;
    for (int i = 0; i < 10; i++) drive(2'b01, 1'b1, pk(i >= 6 ? 2'b01 : 2'b00, i == 6 ? 2'b01 : 2'b00, 2'b00, 2'b00));
    for (int i = 0; i < 10; i++) drive(2'b00, 1'b1, pk(i < 6 ? 2'b01 : 2'b00, 2'b00, i == 6 ? 2'b01 : 2'b00, 2'b00));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL clean_press vec %0d: lvl/prs/rel/lng got %b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_bounce;
    logic [7:0] e, o;
    logic [1:0] pat[7] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
    int n = 0;
    for (int i = 0; i < 17; i++)
      drive(i < 7 ? pat[i] : 2'b01, 1'b1, pk(i >= 12 ? 2'b01 : 2'b00, i == 12 ? 2'b01 : 2'b00, 2'b00, 2'b00));
    for (int i = 0; i < 10; i++) drive(2'b00, 1'b1, pk(i < 6 ? 2'b01 : 2'b00, 2'b00, i == 6 ? 2'b01 : 2'b00, 2'b00));
    for (int len = 3; len <= 4; len++)
      for (int i = 0; i < len + 8; i++) drive(i < len ? 2'b01 : 2'b00, 1'b1, 8'h00);
    for (int i = 0; i < 14; i++)
      drive(i < 5 ? 2'b01 : 2'b00, 1'b1,
            pk(i >= 6 && i < 11 ? 2'b01 : 2'b00, i == 6 ? 2'b01 : 2'b00, i == 11 ? 2'b01 : 2'b00, 2'b00));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL bounce vec %0d: lvl/prs/rel/lng got %b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_independent;
    logic [7:0] e, o;
    int n = 0;
    for (int i = 0; i < 10; i++) drive(2'b11, 1'b1, pk(i >= 6 ? 2'b11 : 2'b00, i == 6 ? 2'b11 : 2'b00, 2'b00, 2'b00));
    for (int i = 0; i < 10; i++) drive(2'b01, 1'b1, pk(i >= 6 ? 2'b01 : 2'b11, 2'b00, i == 6 ? 2'b10 : 2'b00, 2'b00));
    for (int i = 0; i < 10; i++) drive(2'b00, 1'b1, pk(i < 6 ? 2'b01 : 2'b00, 2'b00, i == 6 ? 2'b01 : 2'b00, 2'b00));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL independent vec %0d: lvl/prs/rel/lng got %b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0] e, o;
    int n = 0;
    for (int i = 0; i < 4; i++) drive(2'b01, 1'b1, 8'h00);
    drive(2'b01, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) drive(2'b01, 1'b1, pk(i >= 6 ? 2'b01 : 2'b00, i == 6 ? 2'b01 : 2'b00, 2'b00, 2'b00));
    for (int i = 0; i < 10; i++) drive(2'b00, 1'b1, pk(i < 6 ? 2'b01 : 2'b00, 2'b00, i == 6 ? 2'b01 : 2'b00, 2'b00));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL mid_reset vec %0d: lvl/prs/rel/lng got %b want %b", n, o, e);
      end
      n++;
    end
  endtask

  // A 2-cycle drop keeps the FSM out of HIGH for two edges, so the long pulse lands at 28, not 26.
  task automatic test_long_press;
    logic [7:0] e, o;
    int n = 0;
    for (int i = 0; i < 47; i++)
      drive(i == 10 || i == 11 ? 2'b00 : 2'b01, 1'b1,
            pk(i >= 6 ? 2'b01 : 2'b00, i == 6 ? 2'b01 : 2'b00, 2'b00, LONG_EN && i == 28 ? 2'b01 : 2'b00));
    for (int i = 0; i < 10; i++) drive(2'b00, 1'b1, pk(i < 6 ? 2'b01 : 2'b00, 2'b00, i == 6 ? 2'b01 : 2'b00, 2'b00));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL long_press vec %0d: lvl/prs/rel/lng got %b want %b", n, o, e);
      end
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_independent();
    test_mid_reset();
    test_long_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
